id_ex_pipe_skid: RTL and testbench
==================================

Name: id_ex_pipe_skid

Overview:
- Parametrised ID/EX pipeline register for the 19-bit pipelined CPU.
- Successor to the plain ID/EX latch: adds a valid/ready handshake, a 2-entry skid buffer so `id_ready` is registered, and a synchronous flush that inserts bubbles.
- Adds a saturating stall-cycle counter.
- Sits between the decode/register-read stage and the ALU stage.

Parameters:
- DATA_W, 19, width of register read data `rd1`/`rd2`
- OPC_W, 5, opcode width
- IMM_W, 8, immediate width
- RA_W, 3, register address width (rs/rt/rd)
- CTRL_W, 7, control bundle width; bit map is in the package
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill all held entries and any same-cycle input
- id_valid  in  1  decode stage presents an instruction
- id_ready  out  1  stage can accept; registered
- id_opcode  in  OPC_W  opcode
- id_ctrl  in  CTRL_W  control bundle
- id_imm  in  IMM_W  immediate
- id_rs, id_rt, id_rd  in  RA_W each  register addresses
- id_rd1, id_rd2  in  DATA_W each  operand data
- ex_valid  out  1  entry presented to EX
- ex_ready  in  1  EX consumes this cycle
- ex_opcode, ex_ctrl, ex_imm, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2  out  (same widths)  head-entry fields
- stall_cnt  out  CNT_W  cycles with `ex_valid && !ex_ready`

Behaviour:
- Clock and reset: one clock `clk`; `rst` synchronous active-high. Every register updates only on the rising edge of `clk`.
- Reset values: `ex_valid=0`; all `ex_*` fields = 0; `stall_cnt=0`; `id_ready=1`; skid entry empty.
- Handshake:
  - Accept = `id_valid && id_ready`.
  - Consume = `ex_valid && ex_ready`.
  - `id_valid`/fields may change freely when `id_ready=0`.
  - Once asserted, `ex_valid` and `ex_*` are stable until consumed or flushed.
- Storage: `main` (drives `ex_*`) and `skid`.
- States:
  - EMPTY: `main` invalid.
  - ONE: `main` valid, `skid` empty.
  - FULL: both valid.
- Transitions (no flush):
  - EMPTY + accept -> ONE. Data appears on `ex_*` the next cycle (latency 1).
  - ONE + accept + consume -> ONE, `main` := new input.
  - ONE + accept, no consume -> FULL, input captured into `skid`.
  - ONE + consume, no accept -> EMPTY.
  - FULL + consume -> ONE, `main` := `skid`. No accept is possible in FULL.
- `id_ready` is registered: 0 exactly when next state is FULL, else 1.
- Throughput: 1 instruction/cycle while `ex_ready=1`.
- Ordering: strictly FIFO; no duplication or loss except by flush.
- Bubble rule: `ex_ctrl` is forced to 0 whenever `ex_valid=0`. Other `ex_*` fields hold their last values.
- Flush:
  - Highest priority after `rst`.
  - Next cycle: state EMPTY, `ex_valid=0`, `ex_ctrl=0`, `id_ready=1`.
  - Input presented in the flush cycle is discarded even if `id_ready=1`.
  - Consume in the flush cycle still counts as consumed by EX.
- `stall_cnt`:
  - +1 on each cycle with `ex_valid && !ex_ready`.
  - Saturates at all-ones with no wrap.
  - Cleared only by `rst`; `flush` does not clear it.
- Reset mid-operation: same as flush, plus `stall_cnt` cleared.

Decomposition:
- Package `cpu_pipe_pkg`:
  - `CTRL_*` bit indices: 0 regwrite, 1 memtoreg, 2 memread, 3 memwrite, 4 alusrc, 5 aluop, 6 regdist.
  - Default widths.
  - Packed struct `id_ex_payload_t` {opcode, ctrl, imm, rs, rt, rd, rd1, rd2}.
  - State enum {EMPTY, ONE, FULL}.
- One sub-module `pipe_skid_buf`: generic 2-entry skid with WIDTH parameter, operating on the flattened payload.
- Top adds ctrl gating, flush, and `stall_cnt`.

Test Plan:
- Reset then single issue:
  - Stimulus: `rst` for 2 cycles, then payload opcode=5'b10101, ctrl=7'h7F, imm=8'hFF, rs/rt/rd=5/6/7, rd1=19'h1A5A5, rd2=19'h15A5A, one-cycle `id_valid`, `ex_ready=1`.
  - Response: `ex_valid=1` with identical fields exactly one cycle later, then `ex_valid=0` and `ex_ctrl=0`.
- Back-to-back streaming:
  - Stimulus: 8 consecutive instructions, opcode=0..7, `ex_ready=1`.
  - Response: 8 consecutive `ex_valid` cycles in order; `id_ready` never drops.
- Backpressure:
  - Stimulus: `ex_ready=0` with 3 issues attempted (A=01010 with rd1=19'h7FFFF, B, C).
  - Response: A held on `ex_*`; B in skid; `id_ready=0` after B; C not accepted. `stall_cnt` increments each cycle.
  - Then `ex_ready=1` -> A, B, C delivered in order.
- Flush in FULL:
  - Stimulus: `flush` asserted while FULL and `id_valid=1`.
  - Response: next cycle `ex_valid=0`, `ex_ctrl=0`, `id_ready=1`; the flush-cycle input never appears; `stall_cnt` retained.
- Counter saturation:
  - Stimulus: CNT_W=4 build, `ex_ready=0` for 20 cycles with `ex_valid=1`.
  - Response: `stall_cnt` reaches 4'hF and holds.
- Reset mid-stream:
  - Stimulus: `rst` asserted while FULL.
  - Response: next cycle all outputs at reset values, `stall_cnt=0`, `id_ready=1`.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared widths, control bit map, payload struct and skid state enum
package cpu_pipe_pkg;

  // Default datapath widths of the 19-bit CPU
  localparam int DATA_W_DEF = 19;
  localparam int OPC_W_DEF  = 5;
  localparam int IMM_W_DEF  = 8;
  localparam int RA_W_DEF   = 3;
  localparam int CTRL_W_DEF = 7;
  localparam int CNT_W_DEF  = 16;

  // Control bundle bit map
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP    = 5;
  localparam int CTRL_REGDIST  = 6;

  // Field order matches the flattened payload used by the top level
  typedef struct packed {
    logic [OPC_W_DEF-1:0]  opcode;
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [IMM_W_DEF-1:0]  imm;
    logic [RA_W_DEF-1:0]   rs;
    logic [RA_W_DEF-1:0]   rt;
    logic [RA_W_DEF-1:0]   rd;
    logic [DATA_W_DEF-1:0] rd1;
    logic [DATA_W_DEF-1:0] rd2;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer with registered ready and flush
module pipe_skid_buf
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             consume;

  // ready is a flop, so accept never depends combinationally on out_ready
  assign accept  = in_valid && ready_q;
  assign consume = (state_q != EMPTY) && out_ready;

  // State, entry storage and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // Next state and entry movement; flush drops everything but leaves stale data in place
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  // Outputs are taken straight from the head entry and the ready flop
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    in_ready  = ready_q;
  end

endmodule

// File: rtl/id_ex_pipe_skid.sv
// rtl/id_ex_pipe_skid.sv - ID/EX pipeline register with skid buffer, bubble gating and stall counter
module id_ex_pipe_skid
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = OPC_W + CTRL_W + IMM_W + 3 * RA_W + 2 * DATA_W;

  logic [PAY_W-1:0]  in_pay;
  logic [PAY_W-1:0]  out_pay;
  logic [CTRL_W-1:0] ctrl_raw;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign in_pay = {id_opcode, id_ctrl, id_imm, id_rs, id_rt, id_rd, id_rd1, id_rd2};

  pipe_skid_buf #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (id_valid),
    .in_ready  (id_ready),
    .in_data   (in_pay),
    .out_valid (ex_valid),
    .out_ready (ex_ready),
    .out_data  (out_pay)
  );

  assign {ex_opcode, ctrl_raw, ex_imm, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2} = out_pay;

  // A bubble carries no control so EX never writes back or touches memory
  assign ex_ctrl = ex_valid ? ctrl_raw : '0;

  // Saturating count of cycles where EX holds off a valid entry
  always_comb begin
    stall_d = stall_q;
    if (ex_valid && !ex_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Counter register; only reset clears it, flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_skid.sv
// tb/tb_id_ex_pipe_skid.sv - randomized and directed bench for id_ex_pipe_skid against a queue model
module tb_id_ex_pipe_skid;
  import cpu_pipe_pkg::*;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, flush, id_valid, id_ready, ex_valid, ex_ready;
  logic [OPC_W_DEF-1:0]  id_opcode, ex_opcode;
  logic [CTRL_W_DEF-1:0] id_ctrl, ex_ctrl;
  logic [IMM_W_DEF-1:0]  id_imm, ex_imm;
  logic [RA_W_DEF-1:0]   id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
  logic [DATA_W_DEF-1:0] id_rd1, id_rd2, ex_rd1, ex_rd2;
  logic [CW-1:0]         stall_cnt;

  always #5 clk = ~clk;

  id_ex_pipe_skid #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_ctrl(id_ctrl), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad = 0;

  // Reference model: an in-order queue of at most two instructions
  id_ex_payload_t mq[$];
  id_ex_payload_t last_shown;
  int             m_cnt;
  bit             m_ready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic id_ex_payload_t mk(input int op);
    id_ex_payload_t p;
    p.opcode = OPC_W_DEF'(op);
    p.ctrl   = CTRL_W_DEF'(op * 13 + 1);
    p.imm    = IMM_W_DEF'(op * 37 + 5);
    p.rs     = RA_W_DEF'(op);
    p.rt     = RA_W_DEF'(op + 1);
    p.rd     = RA_W_DEF'(op + 2);
    p.rd1    = DATA_W_DEF'(op * 4099);
    p.rd2    = DATA_W_DEF'(~(op * 311));
    return p;
  endfunction

  function automatic id_ex_payload_t rnd_pay();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[$bits(id_ex_payload_t)-1:0];
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input bit v, input id_ex_payload_t p, input bit er, input bit fl, input bit r);
    bit acc, con;
    id_ex_payload_t exp_p;
    id_ex_payload_t obs_p;
    id_valid = v;
    {id_opcode, id_ctrl, id_imm, id_rs, id_rt, id_rd, id_rd1, id_rd2} = p;
    ex_ready = er;
    flush = fl;
    rst = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_cnt = 0;
      m_ready = 1'b1;
      last_shown = '0;
    end else begin
      acc = v && m_ready;
      con = (mq.size() > 0) && er;
      if ((mq.size() > 0) && !er && (m_cnt < CMAX)) m_cnt++;
      if (fl) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(p);
      end
      m_ready = (mq.size() < 2);
    end
    if (mq.size() > 0) begin
      last_shown = mq[0];
      exp_p = mq[0];
    end else begin
      exp_p = last_shown;
      exp_p.ctrl = '0;
    end
    #1;
    obs_p = {ex_opcode, ex_ctrl, ex_imm, ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2};
    chk("ex_valid", 128'(ex_valid), 128'(mq.size() > 0));
    chk("id_ready", 128'(id_ready), 128'(m_ready));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
    chk("ex_payload", 128'(obs_p), 128'(exp_p));
  endtask

  id_ex_payload_t p1, pa, pb, pc, pd, px;

  initial begin
    m_cnt = 0;
    m_ready = 1'b1;
    last_shown = '0;
    id_valid = 1'b0;
    ex_ready = 1'b0;
    flush = 1'b0;
    rst = 1'b1;
    {id_opcode, id_ctrl, id_imm, id_rs, id_rt, id_rd, id_rd1, id_rd2} = '0;

    // Reset for two cycles
    step(0, '0, 1, 0, 1);
    step(0, '0, 1, 0, 1);
    chk("reset_stall", 128'(stall_cnt), 128'(0));
    chk("reset_ready", 128'(id_ready), 128'(1));

    // Single issue, latency one
    p1.opcode = 5'b10101; p1.ctrl = 7'h7F; p1.imm = 8'hFF;
    p1.rs = 3'd5; p1.rt = 3'd6; p1.rd = 3'd7;
    p1.rd1 = 19'h1A5A5; p1.rd2 = 19'h15A5A;
    step(1, p1, 1, 0, 0);
    chk("single_opcode", 128'(ex_opcode), 128'(5'b10101));
    chk("single_rd1", 128'(ex_rd1), 128'(19'h1A5A5));
    step(0, '0, 1, 0, 0);
    chk("single_bubble_ctrl", 128'(ex_ctrl), 128'(0));

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      step(1, mk(i), 1, 0, 0);
      chk("stream_ready", 128'(id_ready), 128'(1));
      chk("stream_opcode", 128'(ex_opcode), 128'(i));
    end
    step(0, '0, 1, 0, 0);

    // Backpressure: A held, B skidded, C refused
    pa = mk(20); pa.opcode = 5'b01010; pa.rd1 = 19'h7FFFF;
    pb = mk(21); pc = mk(22);
    step(1, pa, 0, 0, 0);
    step(1, pb, 0, 0, 0);
    chk("bp_ready_low", 128'(id_ready), 128'(0));
    step(1, pc, 0, 0, 0);
    step(1, pc, 0, 0, 0);
    chk("bp_head_a", 128'(ex_rd1), 128'(19'h7FFFF));
    chk("bp_stall3", 128'(stall_cnt), 128'(3));
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(1, pc, 1, 0, 0);
    chk("bp_deliver_c", 128'(ex_opcode), 128'(pc.opcode));
    step(0, '0, 1, 0, 0);

    // Flush while full; flush-cycle input discarded, counter kept
    pd = mk(30);
    step(1, mk(28), 0, 0, 0);
    step(1, mk(29), 0, 0, 0);
    step(1, pd, 0, 1, 0);
    chk("flush_valid", 128'(ex_valid), 128'(0));
    chk("flush_ctrl", 128'(ex_ctrl), 128'(0));
    chk("flush_ready", 128'(id_ready), 128'(1));
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);

    // Counter saturation
    step(1, mk(40), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0);
    chk("sat_value", 128'(stall_cnt), 128'(4'hF));
    step(0, '0, 1, 0, 0);

    // Reset while full
    px = mk(50);
    step(1, mk(48), 0, 0, 0);
    step(1, mk(49), 0, 0, 0);
    step(1, px, 0, 0, 1);
    chk("rst_mid_stall", 128'(stall_cnt), 128'(0));
    chk("rst_mid_ready", 128'(id_ready), 128'(1));
    chk("rst_mid_opcode", 128'(ex_opcode), 128'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), rnd_pay(),
           bit'($urandom_range(0, 9) < 6),
           bit'($urandom_range(0, 39) == 0),
           bit'($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
